// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// Deserialises the one-bit-per-clock frame stream produced by the UART
// transmit stage. The frame is a start bit, 8 data slots (LSB first), a
// parity slot, and 1 or 2 stop bits. The recovered byte and its parity and
// framing status are held in an output register until the consumer acks it.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   rxd      serial line, idle high, one bit per clk
//   par      parity mode: 00 XOR, 11 XNOR, 01/10 no parity check
//   snum     0 = two stop bits, 1 = one stop bit
//   dnum     1 = 7-bit data (dout[7] forced 0), 0 = 8-bit data
//   ack      single-cycle consumer acknowledge
//   dout     held data byte
//   valid    held frame not yet acknowledged
//   par_err  parity mismatch on held frame
//   frm_err  a stop bit sampled low on held frame
//   ovr_err  a frame completed over an unacknowledged one (sticky until ack)
//   busy     frame reception in progress
module uart_rx_deser #(
  parameter int SYNC_STAGES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic [1:0] par,
  input  logic       snum,
  input  logic       dnum,
  input  logic       ack,
  output logic [7:0] dout,
  output logic       valid,
  output logic       par_err,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_t;

  // Returns 1 when the received parity slot disagrees with the expected
  // parity for the given mode; modes without parity never mismatch.
  function automatic logic par_mismatch(input logic [7:0] data,
                                        input logic [1:0] mode,
                                        input logic       bit_in);
    logic mm;
    case (mode)
      2'b00:   mm = bit_in ^ (^data);
      2'b11:   mm = bit_in ^ ~(^data);
      default: mm = 1'b0;
    endcase
    return mm;
  endfunction

  logic line_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign line_s = rxd;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Synchroniser chain on the serial line; resets to the idle level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
          sync_r[0] <= rxd;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign line_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  state_t     state_r, state_n;
  logic [2:0] bit_cnt_r, bit_cnt_n;
  logic [7:0] shift_r, shift_n;
  logic       par_bit_r, par_bit_n;
  logic       stop_bad_r, stop_bad_n;
  logic [1:0] cfg_par_r, cfg_par_n;
  logic       cfg_snum_r, cfg_snum_n;
  logic       cfg_dnum_r, cfg_dnum_n;
  logic [7:0] dout_r, dout_n;
  logic       valid_r, valid_n;
  logic       par_err_r, par_err_n;
  logic       frm_err_r, frm_err_n;
  logic       ovr_err_r, ovr_err_n;
  logic       busy_r, busy_n;
  logic       done_s;
  logic       frm_now_s;

  // Next-state and next-output logic for the frame FSM and output register.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    par_bit_n  = par_bit_r;
    stop_bad_n = stop_bad_r;
    cfg_par_n  = cfg_par_r;
    cfg_snum_n = cfg_snum_r;
    cfg_dnum_n = cfg_dnum_r;
    dout_n     = dout_r;
    valid_n    = valid_r;
    par_err_n  = par_err_r;
    frm_err_n  = frm_err_r;
    ovr_err_n  = ovr_err_r;
    done_s     = 1'b0;
    frm_now_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (!line_s) begin
          // Config is frozen for the whole frame at the start edge.
          state_n    = ST_DATA;
          bit_cnt_n  = 3'd0;
          stop_bad_n = 1'b0;
          cfg_par_n  = par;
          cfg_snum_n = snum;
          cfg_dnum_n = dnum;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        // LSB arrives first, so shift in from the top.
        shift_n   = {line_s, shift_r[7:1]};
        bit_cnt_n = bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          state_n = ST_PARITY;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        par_bit_n = line_s;
        state_n   = ST_STOP1;
      end
      ST_STOP1: begin
        stop_bad_n = ~line_s;
        if (cfg_snum_r) begin
          done_s    = 1'b1;
          frm_now_s = ~line_s;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_STOP2;
        end
      end
      ST_STOP2: begin
        done_s    = 1'b1;
        frm_now_s = stop_bad_r | ~line_s;
        state_n   = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (done_s) begin
      dout_n    = {(cfg_dnum_r ? 1'b0 : shift_r[7]), shift_r[6:0]};
      par_err_n = par_mismatch(shift_r, cfg_par_r, par_bit_r);
      frm_err_n = frm_now_s;
      valid_n   = 1'b1;
      // A same-edge ack consumes the old frame, so it is not an overrun.
      if (valid_r && !ack) begin
        ovr_err_n = 1'b1;
      end else if (ack) begin
        ovr_err_n = 1'b0;
      end else begin
        ovr_err_n = ovr_err_r;
      end
    end else if (ack && valid_r) begin
      valid_n   = 1'b0;
      par_err_n = 1'b0;
      frm_err_n = 1'b0;
      ovr_err_n = 1'b0;
    end else begin
      valid_n = valid_r;
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      par_bit_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      cfg_par_r  <= 2'd0;
      cfg_snum_r <= 1'b0;
      cfg_dnum_r <= 1'b0;
      dout_r     <= 8'd0;
      valid_r    <= 1'b0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      ovr_err_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      par_bit_r  <= par_bit_n;
      stop_bad_r <= stop_bad_n;
      cfg_par_r  <= cfg_par_n;
      cfg_snum_r <= cfg_snum_n;
      cfg_dnum_r <= cfg_dnum_n;
      dout_r     <= dout_n;
      valid_r    <= valid_n;
      par_err_r  <= par_err_n;
      frm_err_r  <= frm_err_n;
      ovr_err_r  <= ovr_err_n;
      busy_r     <= busy_n;
    end
  end

  assign dout    = dout_r;
  assign valid   = valid_r;
  assign par_err = par_err_r;
  assign frm_err = frm_err_r;
  assign ovr_err = ovr_err_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
// Directed bench for uart_rx_deser. Two instances share the stimulus: one
// with no synchroniser and one with SYNC_STAGES=2 (checked for latency).
module tb_uart_rx_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] par = 2'b00;
  logic       snum = 1'b0;
  logic       dnum = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] dout, dout2;
  logic       valid, par_err, frm_err, ovr_err, busy;
  logic       valid2, par_err2, frm_err2, ovr_err2, busy2;

  int n_assert = 0;
  int n_fail   = 0;

  int   cyc       = 0;
  int   rise_cnt  = 0;
  int   last_rise = 0;
  int   prev_rise = 0;
  logic valid_q   = 1'b0;
  int   rc0;

  uart_rx_deser #(.SYNC_STAGES(0)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .par(par), .snum(snum), .dnum(dnum),
    .ack(ack), .dout(dout), .valid(valid), .par_err(par_err),
    .frm_err(frm_err), .ovr_err(ovr_err), .busy(busy)
  );

  uart_rx_deser #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .rxd(rxd), .par(par), .snum(snum), .dnum(dnum),
    .ack(ack), .dout(dout2), .valid(valid2), .par_err(par_err2),
    .frm_err(frm_err2), .ovr_err(ovr_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle of each rising edge of valid on the first instance.
  always @(negedge clk) begin
    valid_q <= valid;
    if (valid && !valid_q) begin
      rise_cnt  <= rise_cnt + 1;
      prev_rise <= last_rise;
      last_rise <= cyc;
    end
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic a);
    rxd = b;
    ack = a;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic s1,
                            input logic s2, input logic two,
                            input logic ack_start, input logic ack_end);
    send_bit(1'b0, ack_start);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(pb, 1'b0);
    if (two) begin
      send_bit(s1, 1'b0);
      send_bit(s2, ack_end);
    end else begin
      send_bit(s1, ack_end);
    end
    rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    send_bit(1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] nom;
    nom = 8'hA5;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ovr", ovr_err, 1'b0);
    rst = 1'b1;
    repeat (2) send_bit(1'b1, 1'b0);

    // Nominal frame 0xA5, even parity 0, two stop bits
    par = 2'b00; snum = 1'b0; dnum = 1'b0;
    send_bit(1'b0, 1'b0);
    chk1("nom_busy_k", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(nom[i], 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk1("nom_busy_k10", busy, 1'b1);
    chk1("nom_valid_k10", valid, 1'b0);
    send_bit(1'b1, 1'b0);
    rxd = 1'b1;
    chk1("nom_valid", valid, 1'b1);
    chk8("nom_dout", dout, 8'hA5);
    chk1("nom_par_err", par_err, 1'b0);
    chk1("nom_frm_err", frm_err, 1'b0);
    chk1("nom_busy_end", busy, 1'b0);
    ack_pulse();
    chk1("nom_ack_valid", valid, 1'b0);
    chk8("nom_ack_dout_hold", dout, 8'hA5);

    // Parity error with XNOR: 0x3C has four ones, expected slot 1, sent 0
    par = 2'b11;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk8("perr_dout", dout, 8'h3C);
    chk1("perr_par_err", par_err, 1'b1);
    ack_pulse();
    chk1("perr_ack_clr", par_err, 1'b0);
    par = 2'b01;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk8("pnone_dout", dout, 8'h3C);
    chk1("pnone_par_err", par_err, 1'b0);
    ack_pulse();

    // 7-bit data: slot 7 = 1 is dropped but still counted in parity
    par = 2'b00; snum = 1'b1; dnum = 1'b1;
    send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk8("d7_dout", dout, 8'h2A);
    chk1("d7_par_err", par_err, 1'b0);
    ack_pulse();

    // Back-to-back frames, one stop bit, ack at next start bit
    rc0 = rise_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("b2b_valid1", valid, 1'b1);
    chk8("b2b_dout1", dout, 8'h55);
    send_frame(8'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk1("b2b_valid2", valid, 1'b1);
    chk8("b2b_dout2", dout, 8'h2A);
    chk1("b2b_par_err2", par_err, 1'b0);
    chk1("b2b_ovr", ovr_err, 1'b0);
    #5;
    chki("b2b_rises", rise_cnt - rc0, 2);
    chki("b2b_spacing", last_rise - prev_rise, 11);
    ack_pulse();

    // Framing errors: stop2 low, then stop1 low
    par = 2'b01; snum = 1'b0; dnum = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk8("ferr_dout", dout, 8'h0F);
    chk1("ferr_frm2", frm_err, 1'b1);
    chk1("ferr_idle", busy, 1'b0);
    ack_pulse();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk8("ferr1_dout", dout, 8'hF0);
    chk1("ferr_frm1", frm_err, 1'b1);
    ack_pulse();
    chk1("ferr_ack_clr", frm_err, 1'b0);

    // Overrun, then ack coincident with a completion
    snum = 1'b1;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ovr_first_clean", ovr_err, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("ovr_set", ovr_err, 1'b1);
    chk8("ovr_dout", dout, 8'h22);
    chk1("ovr_valid", valid, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk1("same_edge_valid", valid, 1'b1);
    chk1("same_edge_ovr", ovr_err, 1'b0);
    chk8("same_edge_dout", dout, 8'h33);
    ack_pulse();
    chk1("same_edge_ack", valid, 1'b0);
    send_bit(1'b1, 1'b1);
    chk8("ack_idle_dout", dout, 8'h33);

    // Reset mid-frame while a frame is held
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk8("mrst_dout", dout, 8'h00);
    chk1("mrst_valid", valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) send_bit(1'b1, 1'b0);
    chk1("mrst_no_valid", valid, 1'b0);
    par = 2'b00; snum = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("post_rst_valid", valid, 1'b1);
    chk8("post_rst_dout", dout, 8'hC3);
    chk1("post_rst_par", par_err, 1'b0);

    // Nominal frame through the 2-stage synchroniser
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) send_bit(1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("sync0_valid", valid, 1'b1);
    chk1("sync2_valid_k11", valid2, 1'b0);
    chk1("sync2_busy_k11", busy2, 1'b1);
    send_bit(1'b1, 1'b0);
    chk1("sync2_valid_k12", valid2, 1'b0);
    send_bit(1'b1, 1'b0);
    chk1("sync2_valid_k13", valid2, 1'b1);
    chk8("sync2_dout", dout2, 8'hA5);
    chk1("sync2_busy_end", busy2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
